shift_rows_col_feeder: RTL and testbench

- Upstream neighbour of the column mixer in the iterative AES datapath.
- Accepts a 128-bit post-SubBytes state over a valid/ready handshake and applies ShiftRows (or InvShiftRows).
- Emits the result as four 32-bit column words, one per cycle, over a second valid/ready handshake into the column mixer.
- Byte 0 of each column word is bits [31:24], matching the column mixer's input packing.

---
 rtl/aes_pkg.sv | 18 +
 rtl/shift_rows_col_feeder_if.sv | 25 ++
 rtl/aes_shift_rows.sv | 21 ++
 rtl/shift_rows_col_feeder.sv | 97 +++++++++
 tb/tb_shift_rows_col_feeder.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES datapath types, sizes and the state byte indexing helper.
// State byte s(4c+r) is row r, column c, with s0 in bits [127:120].
package aes_pkg;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  word_t;
  typedef logic [7:0]   byte_t;

  localparam int NB       = 4;
  localparam int NUM_COLS = 4;

  function automatic byte_t state_byte(input state_t s, input int row, input int col);
    int base;
    base = 127 - 8 * (4 * col + row);
    return s[base -: 8];
  endfunction

endpackage

// File: rtl/shift_rows_col_feeder_if.sv
// Handshake bundle between the state producer, the feeder and the column mixer.
// The master drives the input state and the downstream ready.
interface shift_rows_col_feeder_if;
  import aes_pkg::*;

  logic        in_valid;
  logic        in_ready;
  state_t      in_state;
  logic        out_valid;
  logic        out_ready;
  word_t       out_col;
  logic [1:0]  out_idx;
  logic        out_last;

  modport master (
    output in_valid, in_state, out_ready,
    input  in_ready, out_valid, out_col, out_idx, out_last
  );

  modport slave (
    input  in_valid, in_state, out_ready,
    output in_ready, out_valid, out_col, out_idx, out_last
  );

endinterface

// File: rtl/aes_shift_rows.sv
// Combinational ShiftRows / InvShiftRows byte permutation on a full state.
// Also used by the final round, which bypasses the column mixer.
module aes_shift_rows
  import aes_pkg::*;
#(
  parameter bit INV = 1'b0
) (
  input  state_t in_state,
  output state_t out_state
);

  for (genvar r = 0; r < NB; r++) begin : g_row
    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
      // Forward rotates row r left by r; inverse rotates it right by r.
      localparam int SRC = INV ? ((c + NB - r) % NB) : ((c + r) % NB);
      localparam int DST = 127 - 8 * (4 * c + r);
      assign out_state[DST -: 8] = state_byte(in_state, r, SRC);
    end
  end

endmodule

// File: rtl/shift_rows_col_feeder.sv
// Accepts a 128-bit state, applies (Inv)ShiftRows and streams it to the
// column mixer as four 32-bit column words, back-to-back at full throughput.
module shift_rows_col_feeder
  import aes_pkg::*;
#(
  parameter bit INV = 1'b0
) (
  input logic                      clk,
  input logic                      rst_n,
  shift_rows_col_feeder_if.slave   bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  logic [0:0] state_r;
  logic [0:0] state_s;
  logic [1:0] col_cnt_r;
  logic [1:0] col_cnt_s;
  state_t     hold_r;
  state_t     hold_s;
  state_t     shifted_s;
  logic       in_hs_s;
  logic       out_hs_s;
  logic       last_hs_s;

  aes_shift_rows #(.INV(INV)) u_shift_rows (
    .in_state  (bus.in_state),
    .out_state (shifted_s)
  );

  assign out_hs_s  = bus.out_valid & bus.out_ready;
  assign last_hs_s = out_hs_s & (col_cnt_r == 2'd3);
  assign in_hs_s   = bus.in_valid & bus.in_ready;

  assign bus.in_ready  = (state_r == IDLE) | last_hs_s;
  assign bus.out_valid = (state_r == EMIT);
  assign bus.out_idx   = col_cnt_r;
  assign bus.out_last  = (state_r == EMIT) & (col_cnt_r == 2'd3);
  // The hold register shifts up one column per handshake, so the current
  // column is always its top word and out_col comes straight from a register.
  assign bus.out_col   = hold_r[127:96];

  // Next-state, column counter and hold register update.
  always_comb begin
    state_s   = state_r;
    col_cnt_s = col_cnt_r;
    hold_s    = hold_r;
    case (state_r)
      IDLE: begin
        if (in_hs_s) begin
          state_s   = EMIT;
          col_cnt_s = 2'd0;
          hold_s    = shifted_s;
        end else begin
          state_s   = IDLE;
        end
      end
      EMIT: begin
        if (last_hs_s) begin
          col_cnt_s = 2'd0;
          if (in_hs_s) begin
            state_s = EMIT;
            hold_s  = shifted_s;
          end else begin
            state_s = IDLE;
            hold_s  = {hold_r[95:0], 32'h0000_0000};
          end
        end else if (out_hs_s) begin
          col_cnt_s = col_cnt_r + 2'd1;
          hold_s    = {hold_r[95:0], 32'h0000_0000};
        end else begin
          state_s   = EMIT;
        end
      end
      default: begin
        state_s   = IDLE;
        col_cnt_s = 2'd0;
        hold_s    = '0;
      end
    endcase
  end

  // State registers with asynchronous reset; a reset mid-stream drops the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      col_cnt_r <= 2'd0;
      hold_r    <= '0;
    end else begin
      state_r   <= state_s;
      col_cnt_r <= col_cnt_s;
      hold_r    <= hold_s;
    end
  end

endmodule

// File: tb/tb_shift_rows_col_feeder.sv
// Directed plus randomized bench for both ShiftRows directions, against a
// queue-based model built from byte rows rotated by their row index.
module tb_shift_rows_col_feeder;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [127:0] in_state;
  logic         out_ready;

  int n_checks;
  int n_pass;

  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];

  shift_rows_col_feeder_if ifa ();
  shift_rows_col_feeder_if ifb ();

  assign ifa.in_valid  = in_valid;
  assign ifa.in_state  = in_state;
  assign ifa.out_ready = out_ready;
  assign ifb.in_valid  = in_valid;
  assign ifb.in_state  = in_state;
  assign ifb.out_ready = out_ready;

  shift_rows_col_feeder #(.INV(1'b0)) dut_fwd (.clk(clk), .rst_n(rst_n), .bus(ifa));
  shift_rows_col_feeder #(.INV(1'b1)) dut_inv (.clk(clk), .rst_n(rst_n), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Column c of the shifted state: row r takes its byte from column c+r
  // (forward) or c-r (inverse), modulo 4.
  function automatic logic [31:0] model_col(input logic [127:0] s, input int c, input bit inv);
    logic [7:0] b [16];
    logic [31:0] w;
    int src;
    for (int i = 0; i < 16; i++) b[i] = s[127 - 8 * i -: 8];
    w = 32'h0;
    for (int r = 0; r < 4; r++) begin
      src = inv ? ((c - r + 4) % 4) : ((c + r) % 4);
      w = {w[23:0], b[4 * src + r]};
    end
    return w;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // One clock: compare both DUTs with the model, then advance the model.
  task automatic cycle();
    bit mready;
    bit accept;
    #1;
    mready = (exp_q0.size() == 0) || (exp_q0.size() == 1 && out_ready);
    accept = in_valid && mready;
    check("fwd_in_ready", ifa.in_ready, mready);
    check("inv_in_ready", ifb.in_ready, mready);
    check("fwd_out_valid", ifa.out_valid, exp_q0.size() != 0);
    check("inv_out_valid", ifb.out_valid, exp_q1.size() != 0);
    if (exp_q0.size() != 0) begin
      check("fwd_out_col", ifa.out_col, exp_q0[0]);
      check("inv_out_col", ifb.out_col, exp_q1[0]);
      check("fwd_out_idx", ifa.out_idx, 4 - exp_q0.size());
      check("inv_out_idx", ifb.out_idx, 4 - exp_q1.size());
      check("fwd_out_last", ifa.out_last, exp_q0.size() == 1);
    end else begin
      check("fwd_out_last_idle", ifa.out_last, 1'b0);
    end
    @(posedge clk);
    if (exp_q0.size() != 0 && out_ready) begin
      void'(exp_q0.pop_front());
      void'(exp_q1.pop_front());
    end
    if (accept) begin
      for (int c = 0; c < 4; c++) begin
        exp_q0.push_back(model_col(in_state, c, 1'b0));
        exp_q1.push_back(model_col(in_state, c, 1'b1));
      end
    end
    @(negedge clk);
  endtask

  logic [127:0] fips_in;
  logic [127:0] inv_in;
  logic [31:0]  fips_cols [4];
  logic [31:0]  inv_cols  [4];

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    fips_in   = 128'hd42711aee0bf98f1b8b45de51e415230;
    inv_in    = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    fips_cols = '{32'hd4bf5d30, 32'he0b452ae, 32'hb84111f1, 32'h1e2798e5};
    inv_cols  = '{32'hd42711ae, 32'he0bf98f1, 32'hb8b45de5, 32'h1e415230};
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_state  = fips_in;
    out_ready = 1'b1;

    // Reset state; inputs offered during reset are discarded.
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", ifa.out_valid, 1'b0);
    check("rst_in_ready", ifa.in_ready, 1'b1);
    check("rst_out_col", ifa.out_col, 32'h0);
    check("rst_out_idx", ifa.out_idx, 2'd0);
    check("rst_out_last", ifa.out_last, 1'b0);
    check("rst_inv_out_col", ifb.out_col, 32'h0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // FIPS-197 round 1, full throughput.
    in_valid = 1'b1;
    in_state = fips_in;
    cycle();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("fips_col", ifa.out_col, fips_cols[k]);
      check("fips_idx", ifa.out_idx, k[1:0]);
      check("fips_last", ifa.out_last, k == 3);
      if (k == 0) check("fips_mix_col0", mix_col(ifa.out_col), 32'h046681e5);
      cycle();
    end
    cycle();

    // Inverse direction.
    in_valid = 1'b1;
    in_state = inv_in;
    cycle();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("inv_col", ifb.out_col, inv_cols[k]);
      cycle();
    end

    // Backpressure for 3 cycles while column 1 is presented.
    in_valid = 1'b1;
    in_state = fips_in;
    cycle();
    in_valid = 1'b0;
    cycle();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_col", ifa.out_col, 32'he0b452ae);
      check("bp_idx", ifa.out_idx, 2'd1);
      check("bp_in_ready", ifa.in_ready, 1'b0);
      cycle();
    end
    out_ready = 1'b1;
    cycle();
    check("bp_resume", ifa.out_col, 32'hb84111f1);
    cycle();
    cycle();

    // Back-to-back: second state waits during column 3 of the first.
    in_valid = 1'b1;
    in_state = fips_in;
    cycle();
    in_state = inv_in;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("b2b_valid", ifa.out_valid, 1'b1);
      if (k < 4) check("b2b_in_ready", ifa.in_ready, k == 3);
      if (k == 4) check("b2b_second_col0", ifa.out_col, model_col(inv_in, 0, 1'b0));
      cycle();
      if (k == 3) in_valid = 1'b0;
    end
    cycle();

    // Reset in the middle of a state, after column 1 was taken.
    in_valid = 1'b1;
    in_state = inv_in;
    cycle();
    in_valid = 1'b0;
    cycle();
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", ifa.out_valid, 1'b0);
    check("mid_rst_idx", ifa.out_idx, 2'd0);
    check("mid_rst_inv_valid", ifb.out_valid, 1'b0);
    exp_q0.delete();
    exp_q1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", ifa.in_ready, 1'b1);
    in_valid = 1'b1;
    in_state = fips_in;
    cycle();
    in_valid = 1'b0;
    check("post_rst_idx", ifa.out_idx, 2'd0);
    check("post_rst_col", ifa.out_col, 32'hd4bf5d30);
    repeat (4) cycle();

    // Idle stability.
    for (int k = 0; k < 10; k++) begin
      #1;
      check("idle_valid", ifa.out_valid, 1'b0);
      check("idle_in_ready", ifa.in_ready, 1'b1);
      cycle();
    end

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      in_valid  = $urandom_range(0, 1) == 1;
      out_ready = $urandom_range(0, 3) != 0;
      in_state  = {$urandom, $urandom, $urandom, $urandom};
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
